// File: rtl/gate_test_sequencer.sv
// Exhaustive stimulus/checker for small combinational gates: sweeps every input
// vector, samples the gate at the end of each hold window and reports results.
module gate_test_sequencer #(
  parameter int N_IN  = 2,
  parameter int HOLD  = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       opsel,
  output logic [N_IN-1:0]  dut_in,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [N_IN-1:0]  first_fail_vec,
  output logic             first_fail_valid
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_APPLY = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD - 1);
  localparam logic [N_IN-1:0]  VEC_LAST  = '1;
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  logic [1:0]       state;
  logic [1:0]       op_r;
  logic [N_IN-1:0]  vec;
  logic [HW-1:0]    hold_cnt;
  logic             exp_bit;
  logic             mismatch;
  logic             last_hold;
  logic [ERR_W-1:0] err_next;

  // vec is itself a register and is forced to zero outside APPLY, so the
  // gate inputs stay registered without a second copy.
  assign dut_in = vec;

  always_comb begin
    exp_bit = 1'b0;
    case (op_r)
      2'b00:   exp_bit = &vec;
      2'b01:   exp_bit = |vec;
      2'b10:   exp_bit = ^vec;
      default: exp_bit = ~^vec;
    endcase
  end

  always_comb begin
    mismatch  = (dut_out != exp_bit);
    last_hold = (hold_cnt == HOLD_LAST);
    err_next  = err_count;
    if (mismatch && (err_count != ERR_MAX))
      err_next = err_count + ERR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      op_r             <= '0;
      vec              <= '0;
      hold_cnt         <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_r             <= opsel;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
            pass             <= 1'b0;
            vec              <= '0;
            hold_cnt         <= '0;
            busy             <= 1'b1;
            state            <= S_APPLY;
          end
        end

        S_APPLY: begin
          if (last_hold) begin
            err_count <= err_next;
            if (mismatch && !first_fail_valid) begin
              first_fail_vec   <= vec;
              first_fail_valid <= 1'b1;
            end
            hold_cnt <= '0;
            if (vec == VEC_LAST) begin
              // pass uses err_next so it already reflects the final sample.
              pass  <= (err_next == '0);
              busy  <= 1'b0;
              done  <= 1'b1;
              vec   <= '0;
              state <= S_DONE;
            end else begin
              vec <= vec + N_IN'(1);
            end
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench for gate_test_sequencer: table-driven sweeps against an xorg
// model plus hand-written reset, re-start and saturation sequences.
module tb_gate_test_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start1;
  logic [1:0] opsel, opsel1;
  logic [1:0] dut_in, dut_in1;
  logic       dut_out, dut_out1;
  logic       busy, done, pass, ffvalid;
  logic       busy1, done1, pass1, ffvalid1;
  logic [7:0] err_count;
  logic [0:0] err_count1;
  logic [1:0] ffv, ffv1;
  logic       stuck;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // xorg model, optionally stuck at 0
  assign dut_out  = stuck ? 1'b0 : ^dut_in;
  assign dut_out1 = 1'b0;

  gate_test_sequencer #(.N_IN(2), .HOLD(4), .ERR_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .opsel(opsel),
    .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_fail_vec(ffv),
    .first_fail_valid(ffvalid)
  );

  gate_test_sequencer #(.N_IN(2), .HOLD(1), .ERR_W(1)) u_sat (
    .clk(clk), .rst(rst), .start(start1), .opsel(opsel1),
    .dut_in(dut_in1), .dut_out(dut_out1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err_count1), .first_fail_vec(ffv1),
    .first_fail_valid(ffvalid1)
  );

  typedef struct {
    logic [1:0] op;
    bit         stk;
    int         e_err;
    int         e_ffv;
    bit         e_val;
    bit         e_pass;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sweep(input logic [1:0] op, input bit stk, input int repulse,
                       input int e_err, input int e_ffv, input bit e_val,
                       input bit e_pass);
    int cnt;
    bit seq_ok;
    @(negedge clk);
    stuck = stk;
    opsel = op;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cnt    = 0;
    seq_ok = 1'b1;
    while (busy && cnt < 100) begin
      if (dut_in != 2'(cnt / 4)) seq_ok = 1'b0;
      if (done) seq_ok = 1'b0;
      cnt++;
      start = (cnt == repulse);
      if (cnt == repulse) opsel = 2'b00;
      @(negedge clk);
    end
    start = 1'b0;
    chk("vector_sequence", seq_ok, 1);
    chk("busy_cycles", cnt, 16);
    chk("done_pulse", done, 1);
    chk("dut_in_done", dut_in, 0);
    chk("pass", pass, e_pass);
    chk("err_count", err_count, e_err);
    chk("first_fail_valid", ffvalid, e_val);
    chk("first_fail_vec", ffv, e_ffv);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
    chk("err_count_held", err_count, e_err);
    chk("pass_held", pass, e_pass);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cnt;
    bit  flag;

    tbl[0] = '{2'b10, 1'b0, 0, 0, 1'b0, 1'b1};  // XOR, correct gate
    tbl[1] = '{2'b10, 1'b1, 2, 1, 1'b1, 1'b0};  // XOR, stuck-at-0
    tbl[2] = '{2'b00, 1'b0, 3, 1, 1'b1, 1'b0};  // AND vs xorg
    tbl[3] = '{2'b01, 1'b0, 1, 3, 1'b1, 1'b0};  // OR vs xorg
    tbl[4] = '{2'b11, 1'b0, 4, 0, 1'b1, 1'b0};  // XNOR vs xorg
    tbl[5] = '{2'b00, 1'b1, 1, 3, 1'b1, 1'b0};  // AND, stuck-at-0
    tbl[6] = '{2'b11, 1'b1, 2, 0, 1'b1, 1'b0};  // XNOR, stuck-at-0
    tbl[7] = '{2'b01, 1'b1, 3, 1, 1'b1, 1'b0};  // OR, stuck-at-0

    rst = 1'b1; start = 1'b0; start1 = 1'b0;
    opsel = 2'b00; opsel1 = 2'b00; stuck = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_pass", pass, 0);
    chk("reset_err", err_count, 0);
    chk("reset_dut_in", dut_in, 0);
    chk("reset_ffv", {ffvalid, ffv}, 0);
    chk("reset_sat_all", {busy1, done1, pass1, err_count1, ffvalid1, ffv1, dut_in1}, 0);

    // start during reset resolves as reset
    start = 1'b1;
    @(negedge clk);
    chk("rst_beats_start", busy, 0);
    start = 1'b0;
    rst   = 1'b0;

    for (int i = 0; i < 8; i++)
      sweep(tbl[i].op, tbl[i].stk, -1, tbl[i].e_err, tbl[i].e_ffv,
            tbl[i].e_val, tbl[i].e_pass);

    // start re-pulsed mid-sweep with opsel=AND: ignored, XOR still checked
    sweep(2'b10, 1'b0, 6, 0, 0, 1'b0, 1'b1);

    // reset while dut_in=10 with one mismatch already counted
    @(negedge clk);
    stuck = 1'b1; opsel = 2'b10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_dut_in", dut_in, 2);
    chk("mid_err", err_count, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_dut_in", dut_in, 0);
    chk("abort_err", err_count, 0);
    chk("abort_ffvalid", ffvalid, 0);
    flag = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) flag = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_done", flag, 0);
    sweep(2'b10, 1'b0, -1, 0, 0, 1'b0, 1'b1);

    // HOLD=1, ERR_W=1: counter saturates at 1
    @(negedge clk);
    opsel1 = 2'b10; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cnt = 0;
    while (busy1 && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    chk("sat_busy_cycles", cnt, 4);
    chk("sat_done", done1, 1);
    chk("sat_err", err_count1, 1);
    chk("sat_pass", pass1, 0);
    chk("sat_ffv", {ffvalid1, ffv1}, 3'b101);
    @(negedge clk);
    chk("sat_done_clr", done1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gate_test_sequencer.md
Name: gate_test_sequencer

Overview:
Self-checking stimulus controller for small combinational gates (xorg and its siblings). It steps a gate-under-test through every input combination, holds each vector for a settle window and samples the gate output at the end of that window. It compares each sample against the expected function and reports an error count, the first failing vector and a pass flag. It sits between the board-level start control and the gate instance, replacing hand-written vector lists.

Parameters:
N_IN, 2, gate input width; exhaustive sweep covers 2^N_IN vectors (1..8 supported)
HOLD, 4, cycles each vector is held before sampling (>=1)
ERR_W, 8, error counter width

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  begin a sweep; honoured only in IDLE
opsel  input  2  expected function: 00 AND, 01 OR, 10 XOR, 11 XNOR (reductions over N_IN bits)
dut_in  output  N_IN  vector driven to gate inputs
dut_out  input  1  gate output
busy  output  1  sweep in progress
done  output  1  one-cycle pulse at end of sweep
pass  output  1  err_count==0 for last completed sweep
err_count  output  ERR_W  mismatches in current/last sweep
first_fail_vec  output  N_IN  vector of first mismatch
first_fail_valid  output  1  first_fail_vec holds a captured value

Behaviour:
- Clocking and reset: all outputs registered. Reset is synchronous, active-high, and clears everything: state=IDLE, dut_in=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_valid=0.
- States: IDLE, APPLY, DONE.
- IDLE:
  - busy=0; dut_in held at 0.
  - start=1 at edge k: latch opsel into op_r; clear err_count, first_fail_valid, first_fail_vec and pass; vec=0; hold_cnt=0; state=APPLY.
  - busy=1 from cycle k+1.
- APPLY:
  - dut_in=vec.
  - hold_cnt increments each cycle.
  - On the cycle where hold_cnt==HOLD-1, at its closing edge:
    - sample dut_out and compare with exp = f(op_r, vec);
    - on mismatch, err_count increments, saturating at 2^ERR_W-1;
    - if first_fail_valid=0, capture first_fail_vec=vec and set first_fail_valid=1;
    - then if vec==all-ones, state=DONE, else vec=vec+1 and hold_cnt=0.
  - Each vector is applied for exactly HOLD cycles; the sweep is busy for exactly HOLD*2^N_IN cycles.
  - HOLD=1 means one sample per cycle.
- DONE:
  - Lasts one cycle; done=1, busy=0, dut_in=0.
  - pass is set to (final err_count==0), registered on entry so it is valid in the same cycle as done.
  - Next state is IDLE.
- Holding of results: pass, err_count and first_fail_* hold their values until the next accepted start or reset.
- start ignoring: start in APPLY or DONE is ignored, not queued. opsel changes during a sweep have no effect.
- Expected function: exp uses op_r only.
  - AND = &vec
  - OR = |vec
  - XOR = ^vec
  - XNOR = ~^vec
- Counter widths: vec is N_IN bits wide; the final-vector check uses vec==all-ones, not a wrap. hold_cnt is wide enough for HOLD-1.
- Reset mid-sweep: aborts immediately at that edge. No done pulse. All outputs return to reset values.
- Simultaneous events: rst=1 and start=1 in the same cycle resolves as reset.

Test Plan:
1. N_IN=2, HOLD=4, opsel=10, correct xorg. Pulse start at edge 0 -> dut_in steps 00,01,10,11, each held 4 cycles; busy high for 16 cycles; done pulse 1 cycle later; err_count=0, pass=1, first_fail_valid=0.
2. Same setup, dut_out stuck at 0 -> err_count=2, first_fail_vec=01, first_fail_valid=1, pass=0.
3. Same setup, opsel=00 (AND) against the xorg model -> mismatches at 01, 10 and 11; err_count=3, first_fail_vec=01, pass=0.
4. Start re-pulsed at cycle 6 of a sweep, and opsel changed to 00 mid-sweep -> no restart; sweep still completes at the original time with XOR checking; results as in scenario 1.
5. rst asserted while dut_in=10 -> next cycle busy=0, dut_in=00, err_count=0 and no done pulse. A fresh start then completes a full 16-cycle sweep.
6. ERR_W=1, HOLD=1, stuck-at-0 DUT, XOR -> err_count saturates at 1, busy lasts 4 cycles, pass=0.
